// File: rtl/uart_pkg.sv
// Shared definitions for the uart transmit side: default parameters, the
// arbiter state encoding and a small index-width helper.
package uart_pkg;

    localparam int DEF_NUM_REQ       = 3;
    localparam int DEF_PAYLOAD_BITS  = 8;
    localparam int DEF_START_TIMEOUT = 16;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_START     = 2'd1,
        ARB_WAIT_BUSY = 2'd2,
        ARB_WAIT_DONE = 2'd3
    } arb_state_e;

    // Width of an index into n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: searches upward from (last+1) mod NUM_REQ and returns
// the first active request as a one-hot grant plus its index.
module rr_pick
    import uart_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDXW    = idx_width(DEF_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDXW-1:0]    last,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDXW-1:0]    idx
);

    int   cand;
    logic found;

    // Walk the ring starting just after the previous owner; first hit wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(last) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = IDXW'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NUM_REQ requesters, one byte in flight at a time.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | no transfer; requests sampled, winner and its byte latched
// START      | single cycle: uart_tx_en and ack[owner] asserted
// WAIT_BUSY  | uart_tx_en held until uart_tx reports busy, bounded by timeout
// WAIT_DONE  | byte shifting out; busy falling ends it with done[owner]
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ       = DEF_NUM_REQ,
    parameter int PAYLOAD_BITS  = DEF_PAYLOAD_BITS,
    parameter int START_TIMEOUT = DEF_START_TIMEOUT
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data,
    output logic [NUM_REQ-1:0]              ack,
    output logic [NUM_REQ-1:0]              done,
    output logic                            err,
    output logic                            idle,
    output logic                            uart_tx_en,
    output logic [PAYLOAD_BITS-1:0]         uart_tx_data,
    input  logic                            uart_tx_busy
);

    localparam int IDXW = idx_width(NUM_REQ);
    localparam int CNTW = $clog2(START_TIMEOUT + 1);
    localparam logic [IDXW-1:0] LAST_RST = IDXW'(NUM_REQ - 1);
    localparam logic [CNTW-1:0] CNT_MAX  = CNTW'(START_TIMEOUT);

    arb_state_e               state_q, state_d;
    logic [IDXW-1:0]          owner_q, owner_d;
    logic [IDXW-1:0]          last_q, last_d;
    logic [PAYLOAD_BITS-1:0]  data_q, data_d;
    logic [CNTW-1:0]          cnt_q, cnt_d;
    logic [NUM_REQ-1:0]       done_q, done_d;
    logic                     err_q, err_d;

    logic [NUM_REQ-1:0]       pick_grant;
    logic [IDXW-1:0]          pick_idx;
    logic [PAYLOAD_BITS-1:0]  pick_data;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDXW    (IDXW)
    ) u_rr_pick (
        .req   (req),
        .last  (last_q),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    // AND-OR mux of the winning requester's byte using the one-hot grant.
    always_comb begin
        pick_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) begin
                pick_data = pick_data | req_data[i*PAYLOAD_BITS +: PAYLOAD_BITS];
            end
        end
    end

    // Next-state logic; done/err are computed here and registered so they
    // appear as one-cycle pulses in the IDLE cycle that follows.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        done_d  = '0;
        err_d   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (|req) begin
                    owner_d = pick_idx;
                    data_d  = pick_data;
                    cnt_d   = '0;
                    state_d = ARB_START;
                end
            end
            ARB_START: begin
                state_d = ARB_WAIT_BUSY;
            end
            ARB_WAIT_BUSY: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNTW'(1);
                end
                if (uart_tx_busy) begin
                    state_d = ARB_WAIT_DONE;
                end else if (cnt_d == CNT_MAX) begin
                    err_d   = 1'b1;
                    state_d = ARB_IDLE;
                end
            end
            ARB_WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        done_d[i] = (owner_q == IDXW'(i));
                    end
                    last_d  = owner_q;
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transfer silently.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            last_q  <= LAST_RST;
            data_q  <= '0;
            cnt_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Ack is decoded from the registered state and owner only.
    always_comb begin
        ack = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            ack[i] = (state_q == ARB_START) && (owner_q == IDXW'(i));
        end
    end

    assign idle         = (state_q == ARB_IDLE);
    assign uart_tx_en   = (state_q == ARB_START) || (state_q == ARB_WAIT_BUSY);
    assign uart_tx_data = data_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule
